// File: rtl/apu_pkg.sv
// Shared APU constants: duty table, length/sweep/frequency limits and NRx field positions.
package apu_pkg;
    // Index [duty][7-step]: the leftmost character of each pattern is step 0.
    localparam logic [3:0][7:0] DUTY_TABLE = {8'b01111110, 8'b10000111, 8'b10000001, 8'b00000001};

    localparam int LEN_MAX          = 64;
    localparam int SWEEP_DEF_PERIOD = 8;
    localparam int FREQ_MAX         = 2047;

    localparam int SWP_PER_HI = 6, SWP_PER_LO = 4, SWP_NEG = 3, SWP_SH_HI = 2, SWP_SH_LO = 0;
    localparam int DUTY_HI = 7, DUTY_LO = 6, LEN_HI = 5, LEN_LO = 0;
    localparam int VOL_HI = 7, VOL_LO = 4, ENV_DIR = 3, ENV_PER_HI = 2, ENV_PER_LO = 0, DAC_LO = 3;
    localparam int LEN_EN = 6, FHI_HI = 2, FHI_LO = 0;

    function automatic logic [11:0] sweep_calc(input logic [10:0] f, input logic neg,
                                               input logic [2:0] sh);
        logic [11:0] d;
        d = {1'b0, f >> sh};
        return neg ? ({1'b0, f} - d) : ({1'b0, f} + d);
    endfunction
endpackage

// File: rtl/volume_envelope.sv
// Volume envelope: loads on trigger, steps vol by one on each expired env period, saturating.
module volume_envelope
    import apu_pkg::*;
(
    input  logic       system_clock,
    input  logic       reset_n,
    input  logic       trigger,
    input  logic       env_tick,
    input  logic [3:0] init_vol,
    input  logic       dir_up,
    input  logic [2:0] period,
    output logic [3:0] vol
);
    logic [2:0] cnt;
    logic [2:0] per;
    logic       up;

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            vol <= '0;
            cnt <= '0;
            per <= '0;
            up  <= 1'b0;
        end else if (trigger) begin
            vol <= init_vol;
            cnt <= period;
            per <= period;
            up  <= dir_up;
        end else if (env_tick && per != 3'd0) begin
            if (cnt <= 3'd1) begin
                cnt <= per;
                if (up && vol != 4'hF)
                    vol <= vol + 4'd1;
                else if (!up && vol != 4'h0)
                    vol <= vol - 4'd1;
            end else begin
                cnt <= cnt - 3'd1;
            end
        end
    end
endmodule

// File: rtl/square_channel.sv
// APU square channel: duty sequencer, length counter, volume envelope and optional sweep.
module square_channel
    import apu_pkg::*;
#(
    parameter int OUT_W     = 4,
    parameter int HAS_SWEEP = 1,
    parameter int TICK_DIV  = 4
) (
    input  logic             system_clock,
    input  logic             reset_n,
    input  logic [7:0]       NRx0,
    input  logic [7:0]       NRx1,
    input  logic [7:0]       NRx2,
    input  logic [7:0]       NRx3,
    input  logic [7:0]       NRx4,
    input  logic             trigger,
    input  logic             len_tick,
    input  logic             env_tick,
    input  logic             sweep_tick,
    output logic             enabled,
    output logic [OUT_W-1:0] wave
);
    localparam int TW = $clog2(2048 * TICK_DIV) + 1;
    localparam logic [11:0] FMAX12 = 12'(FREQ_MAX);

    logic [TW-1:0] timer;
    logic [2:0]    step;
    logic [6:0]    len;
    logic [3:0]    vol;
    logic [10:0]   shadow;
    logic [10:0]   reg_freq;
    logic [10:0]   run_freq;
    logic          sweep_kill;
    logic          len_kill;
    logic          dac_on;
    logic          duty_bit;
    logic          unused_bits;

    assign reg_freq    = {NRx4[FHI_HI:FHI_LO], NRx3};
    assign run_freq    = (HAS_SWEEP != 0) ? shadow : reg_freq;
    assign dac_on      = |NRx2[VOL_HI:DAC_LO];
    assign duty_bit    = DUTY_TABLE[NRx1[DUTY_HI:DUTY_LO]][3'd7 - step];
    assign unused_bits = ^{NRx4[7], NRx4[5:3]};

    function automatic logic [TW-1:0] reload(input logic [10:0] f);
        return TW'((2048 - int'(f)) * TICK_DIV - 1);
    endfunction

    // The sequencer only advances while the channel is active; trigger restarts the timer.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
            step  <= '0;
        end else if (trigger) begin
            timer <= reload(reg_freq);
        end else if (enabled) begin
            if (timer == '0) begin
                timer <= reload(run_freq);
                step  <= step + 3'd1;
            end else begin
                timer <= timer - TW'(1);
            end
        end
    end

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n)
            len <= '0;
        else if (trigger)
            len <= 7'(LEN_MAX) - {1'b0, NRx1[LEN_HI:LEN_LO]};
        else if (len_tick && NRx4[LEN_EN] && len != 7'd0)
            len <= len - 7'd1;
    end

    assign len_kill = !trigger && len_tick && NRx4[LEN_EN] && len == 7'd1;

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n)
            enabled <= 1'b0;
        else if (!dac_on)
            enabled <= 1'b0;
        else if (trigger)
            enabled <= !sweep_kill;
        else if (len_kill || sweep_kill)
            enabled <= 1'b0;
    end

    volume_envelope u_env (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .trigger      (trigger),
        .env_tick     (env_tick),
        .init_vol     (NRx2[VOL_HI:VOL_LO]),
        .dir_up       (NRx2[ENV_DIR]),
        .period       (NRx2[ENV_PER_HI:ENV_PER_LO]),
        .vol          (vol)
    );

    generate
        if (HAS_SWEEP != 0) begin : g_sweep
            logic [3:0]  cnt;
            logic [3:0]  cnt_reload;
            logic [2:0]  per;
            logic [2:0]  sh;
            logic        neg;
            logic [11:0] trig_new;
            logic [11:0] tick_new;
            logic [11:0] tick_new2;
            logic        fire;

            assign per        = NRx0[SWP_PER_HI:SWP_PER_LO];
            assign sh         = NRx0[SWP_SH_HI:SWP_SH_LO];
            assign neg        = NRx0[SWP_NEG];
            assign cnt_reload = (per == 3'd0) ? 4'(SWEEP_DEF_PERIOD) : {1'b0, per};
            assign trig_new   = sweep_calc(reg_freq, neg, sh);
            assign tick_new   = sweep_calc(shadow, neg, sh);
            assign tick_new2  = sweep_calc(tick_new[10:0], neg, sh);
            assign fire       = sweep_tick && !trigger && cnt <= 4'd1 && per != 3'd0;

            // After a committed update the next step is pre-checked and can only disable.
            always_comb begin
                sweep_kill = 1'b0;
                if (trigger)
                    sweep_kill = (sh != 3'd0) && (trig_new > FMAX12);
                else if (fire)
                    sweep_kill = (tick_new > FMAX12) || ((sh != 3'd0) && (tick_new2 > FMAX12));
            end

            always_ff @(posedge system_clock or negedge reset_n) begin
                if (!reset_n) begin
                    shadow <= '0;
                    cnt    <= '0;
                end else if (trigger) begin
                    shadow <= reg_freq;
                    cnt    <= cnt_reload;
                end else if (sweep_tick) begin
                    if (cnt <= 4'd1) begin
                        cnt <= cnt_reload;
                        if (per != 3'd0 && sh != 3'd0 && tick_new <= FMAX12)
                            shadow <= tick_new[10:0];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            end
        end else begin : g_no_sweep
            logic unused_sweep;
            assign unused_sweep = ^{NRx0, sweep_tick};
            assign shadow       = '0;
            assign sweep_kill   = 1'b0;
        end
    endgenerate

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n)
            wave <= '0;
        else
            wave <= (enabled && duty_bit) ? (OUT_W'(vol) << (OUT_W - 4)) : '0;
    end
endmodule

// File: tb/tb_square_channel.sv
// Scoreboard bench for square_channel: stimulus queues expected samples, a monitor checks them.
module tb_square_channel;
    logic       system_clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] NRx0 = '0, NRx1 = '0, NRx2 = '0, NRx3 = '0, NRx4 = '0;
    logic       trigger = 1'b0, len_tick = 1'b0, env_tick = 1'b0, sweep_tick = 1'b0;
    logic       enabled;
    logic [3:0] wave;

    typedef struct {
        logic [3:0]  wave;
        logic        en;
        logic        chk_sh;
        logic [10:0] sh;
    } exp_t;

    exp_t  expq[$];
    string nameq[$];
    int    checks = 0;
    int    errors = 0;

    // Hand-written duty patterns, leftmost character = step 0.
    localparam logic [7:0] PAT [4] = '{8'b00000001, 8'b10000001, 8'b10000111, 8'b01111110};

    square_channel #(.OUT_W(4), .HAS_SWEEP(1), .TICK_DIV(4)) u_dut (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .NRx0         (NRx0),
        .NRx1         (NRx1),
        .NRx2         (NRx2),
        .NRx3         (NRx3),
        .NRx4         (NRx4),
        .trigger      (trigger),
        .len_tick     (len_tick),
        .env_tick     (env_tick),
        .sweep_tick   (sweep_tick),
        .enabled      (enabled),
        .wave         (wave)
    );

    always #5 system_clock = ~system_clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    always @(negedge system_clock) begin
        exp_t  e;
        string n;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            n = nameq.pop_front();
            checks++;
            if (wave !== e.wave || enabled !== e.en || (e.chk_sh && u_dut.shadow !== e.sh)) begin
                errors++;
                $display("FAIL %s: wave=%0d enabled=%0b shadow=%0d, expected wave=%0d enabled=%0b shadow=%0d",
                         n, wave, enabled, u_dut.shadow, e.wave, e.en, e.chk_sh ? e.sh : u_dut.shadow);
            end
        end
    end

    task automatic push(input string n, input int w, input bit e, input bit cs = 1'b0, input int sh = 0);
        exp_t x;
        x.wave = 4'(w); x.en = e; x.chk_sh = cs; x.sh = 11'(sh);
        expq.push_back(x);
        nameq.push_back(n);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge system_clock);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 20000) begin
            @(posedge system_clock);
            n++;
        end
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected samples never consumed, required 0", expq.size());
            expq.delete();
            nameq.delete();
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    task automatic set_freq(input int f);
        NRx3 = f[7:0];
        NRx4 = {NRx4[7:3], f[10:8]};
    endtask

    task automatic pulse_trig();
        trigger = 1'b1; cyc(1); trigger = 1'b0;
    endtask

    // Full 8-step waveform from a fresh reset (step starts at 0).
    task automatic wave_test(input string n, input logic [1:0] duty, input int f, input int vol);
        int p;
        logic [7:0] pat;
        p   = (2048 - f) * 4;
        pat = PAT[duty];
        NRx0 = 8'h00; NRx1 = {duty, 6'd0}; NRx2 = {4'(vol), 4'h0}; NRx4 = 8'h00;
        set_freq(f);
        do_reset();
        pulse_trig();
        push({n, "_trig"}, 0, 1'b1);
        for (int s = 0; s < 8; s++)
            for (int c = 0; c < p; c++)
                push($sformatf("%s_s%0d", n, s), pat[7 - s] ? vol : 0, 1'b1);
        drain();
    endtask

    initial begin
        cyc(1);
        push("reset_state", 0, 1'b0, 1'b1, 0);
        drain();

        wave_test("f2047_d2", 2'd2, 2047, 15);
        wave_test("d0", 2'd0, 2040, 15);
        wave_test("d1", 2'd1, 2040, 15);
        wave_test("d2", 2'd2, 2040, 9);
        wave_test("d3", 2'd3, 2040, 15);

        // Length: 64-62 = 2 ticks to expire; f=0 keeps step 0 (high) throughout.
        NRx0 = 8'h00; NRx1 = {2'b10, 6'd62}; NRx2 = 8'hF0; NRx4 = 8'h40; set_freq(0);
        do_reset();
        pulse_trig(); cyc(2);
        push("len_on", 15, 1'b1); drain();
        len_tick = 1'b1; cyc(1); len_tick = 1'b0;
        push("len_tick1", 15, 1'b1); drain();
        len_tick = 1'b1; cyc(1); len_tick = 1'b0;
        push("len_tick2_en", 15, 1'b0);
        push("len_tick2_wave", 0, 1'b0); drain();
        len_tick = 1'b1; cyc(1); len_tick = 1'b0;
        push("len_tick3", 0, 1'b0); drain();

        // Trigger with coincident len_tick: len loads 1 and the tick is dropped.
        NRx1 = {2'b10, 6'd63};
        trigger = 1'b1; len_tick = 1'b1; cyc(1); trigger = 1'b0; len_tick = 1'b0;
        cyc(2);
        push("trig_len_coinc", 15, 1'b1); drain();
        len_tick = 1'b1; cyc(1); len_tick = 1'b0;
        push("len_after_coinc", 15, 1'b0); drain();

        // Envelope up from 14 saturating at 15.
        NRx1 = 8'h80; NRx2 = 8'hE9; NRx4 = 8'h00; set_freq(0);
        do_reset();
        pulse_trig(); cyc(2);
        push("env_init", 14, 1'b1); drain();
        for (int i = 0; i < 3; i++) begin
            env_tick = 1'b1; cyc(1); env_tick = 1'b0;
            push($sformatf("env_up%0d_lat", i), (i == 0) ? 14 : 15, 1'b1);
            push($sformatf("env_up%0d", i), 15, 1'b1);
            drain();
        end

        // DAC off while sounding: enabled drops next cycle, wave one later.
        NRx2 = 8'h00; cyc(1);
        push("dac_off_en", 15, 1'b0);
        push("dac_off_wave", 0, 1'b0); drain();

        // Envelope down from 1 saturating at 0.
        NRx2 = 8'h11;
        pulse_trig(); cyc(2);
        push("env_dn_init", 1, 1'b1); drain();
        for (int i = 0; i < 3; i++) begin
            env_tick = 1'b1; cyc(1); env_tick = 1'b0;
            push($sformatf("env_dn%0d_lat", i), (i == 0) ? 1 : 0, 1'b1);
            push($sformatf("env_dn%0d", i), 0, 1'b1);
            drain();
        end

        // Sweep up, shift 1 from 1024: tick1 commits 1536, and the recheck
        // (1536+768 = 2304 > 2047) disables; tick2 overflows again, shadow held.
        NRx0 = 8'h11; NRx1 = 8'h80; NRx2 = 8'hF0; NRx4 = 8'h00; set_freq(1024);
        do_reset();
        pulse_trig();
        push("swp_trig", 0, 1'b1, 1'b1, 1024); drain();
        sweep_tick = 1'b1; cyc(1); sweep_tick = 1'b0;
        push("swp_tick1", 15, 1'b0, 1'b1, 1536);
        push("swp_tick1_wave", 0, 1'b0, 1'b1, 1536); drain();
        sweep_tick = 1'b1; cyc(1); sweep_tick = 1'b0;
        push("swp_tick2", 0, 1'b0, 1'b1, 1536); drain();

        // Sweep negate: 1024 - 512 = 512, channel stays on.
        NRx0 = 8'h19;
        do_reset();
        pulse_trig();
        push("swp_neg_trig", 0, 1'b1, 1'b1, 1024); drain();
        sweep_tick = 1'b1; cyc(1); sweep_tick = 1'b0;
        push("swp_neg", 15, 1'b1, 1'b1, 512); drain();

        // Overflow check at trigger: 2047 + 1023 > 2047.
        NRx0 = 8'h11; set_freq(2047);
        do_reset();
        pulse_trig();
        push("swp_trig_ovf", 0, 1'b0, 1'b1, 2047); drain();

        // Reset mid-waveform clears immediately and stays cleared until trigger.
        NRx0 = 8'h00; NRx1 = 8'h80; NRx2 = 8'hF0; set_freq(0);
        do_reset();
        pulse_trig(); cyc(2);
        push("pre_rst", 15, 1'b1); drain();
        reset_n = 1'b0;
        push("rst_mid", 0, 1'b0, 1'b1, 0); drain();
        reset_n = 1'b1; cyc(3);
        push("rst_stay0", 0, 1'b0);
        push("rst_stay1", 0, 1'b0); drain();
        pulse_trig();
        push("rst_retrig_en", 0, 1'b1);
        push("rst_retrig_wave", 15, 1'b1); drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
